// File: rtl/intra_filter_accum.sv
// intra_filter_accum
//   Streaming 4-tap angular interpolation stage. Keeps a sliding window of the
//   last four unsigned reference samples, multiplies it by a fixed signed
//   coefficient set, adds the rounding offset, shifts right by 6 and clips the
//   result to 0..255. It produces one predicted sample per window position.
//
//   Pipeline: window (stage 1) -> products (stage 2) -> sum (stage 3) -> out.
//   The whole pipeline advances together on adv = !out_valid || out_ready, so
//   a stalled output freezes every stage, including the window.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input sample valid
//   in_ready   block accepts input this cycle
//   in_sample  unsigned 8-bit reference sample
//   in_last    final sample of a reference line
//   out_valid  predicted sample valid
//   out_ready  downstream accepts output
//   out_sample unsigned clipped predicted sample
//   out_last   output produced by the window closed with in_last
module intra_filter_accum #(
  parameter int                   CW = 8,
  parameter logic signed [CW-1:0] C0 = CW'(-3),
  parameter logic signed [CW-1:0] C1 = CW'(34),
  parameter logic signed [CW-1:0] C2 = CW'(23),
  parameter logic signed [CW-1:0] C3 = CW'(7)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_sample,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_sample,
  output logic       out_last
);

  // Product: 9-bit zero-extended sample times CW-bit coefficient.
  localparam int PW = CW + 9;
  // Sum of four products plus rounding offset.
  localparam int SW = PW + 2;

  logic              rdy_q;
  logic [7:0]        w0_q, w1_q, w2_q, w3_q;
  logic [7:0]        w0_d, w1_d, w2_d, w3_d;
  logic [2:0]        fill_q, fill_d;
  logic              s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic signed [PW-1:0] p0_q, p1_q, p2_q, p3_q;
  logic signed [PW-1:0] p0_d, p1_d, p2_d, p3_d;
  logic              s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
  logic signed [SW-1:0] sum_q, sum_d;
  logic              s3_valid_q, s3_valid_d, s3_last_q, s3_last_d;
  logic              out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [7:0]        out_sample_q, out_sample_d;

  logic              adv;
  logic              accept;
  logic [2:0]        fill_inc;
  logic signed [SW-1:0] r;

  assign adv      = !out_valid_q || out_ready;
  // rdy_q keeps in_ready low during reset and for the first cycle after it.
  assign in_ready = rdy_q && adv;
  assign accept   = in_valid && in_ready;

  assign out_valid  = out_valid_q;
  assign out_sample = out_sample_q;
  assign out_last   = out_last_q;

  assign fill_inc = (fill_q == 3'd4) ? 3'd4 : fill_q + 3'd1;
  assign r        = sum_q >>> 6;

  always_comb begin
    w0_d         = w0_q;
    w1_d         = w1_q;
    w2_d         = w2_q;
    w3_d         = w3_q;
    fill_d       = fill_q;
    s1_valid_d   = s1_valid_q;
    s1_last_d    = s1_last_q;
    p0_d         = p0_q;
    p1_d         = p1_q;
    p2_d         = p2_q;
    p3_d         = p3_q;
    s2_valid_d   = s2_valid_q;
    s2_last_d    = s2_last_q;
    sum_d        = sum_q;
    s3_valid_d   = s3_valid_q;
    s3_last_d    = s3_last_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    out_sample_d = out_sample_q;

    if (adv) begin
      s1_valid_d = 1'b0;
      s1_last_d  = 1'b0;
      if (accept) begin
        w0_d = w1_q;
        w1_d = w2_q;
        w2_d = w3_q;
        w3_d = in_sample;
        // A window completing on in_last still launches before fill clears.
        if (fill_inc == 3'd4) begin
          s1_valid_d = 1'b1;
          s1_last_d  = in_last;
        end
        fill_d = in_last ? 3'd0 : fill_inc;
      end

      p0_d       = PW'($signed({1'b0, w0_q})) * PW'(C0);
      p1_d       = PW'($signed({1'b0, w1_q})) * PW'(C1);
      p2_d       = PW'($signed({1'b0, w2_q})) * PW'(C2);
      p3_d       = PW'($signed({1'b0, w3_q})) * PW'(C3);
      s2_valid_d = s1_valid_q;
      s2_last_d  = s1_last_q;

      sum_d      = SW'(p0_q) + SW'(p1_q) + SW'(p2_q) + SW'(p3_q) + SW'(32);
      s3_valid_d = s2_valid_q;
      s3_last_d  = s2_last_q;

      if (r[SW-1])
        out_sample_d = 8'd0;
      else if (r > SW'(255))
        out_sample_d = 8'd255;
      else
        out_sample_d = r[7:0];
      out_valid_d = s3_valid_q;
      out_last_d  = s3_valid_q && s3_last_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q        <= 1'b0;
      w0_q         <= '0;
      w1_q         <= '0;
      w2_q         <= '0;
      w3_q         <= '0;
      fill_q       <= '0;
      s1_valid_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      p0_q         <= '0;
      p1_q         <= '0;
      p2_q         <= '0;
      p3_q         <= '0;
      s2_valid_q   <= 1'b0;
      s2_last_q    <= 1'b0;
      sum_q        <= '0;
      s3_valid_q   <= 1'b0;
      s3_last_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_sample_q <= '0;
    end else begin
      rdy_q        <= 1'b1;
      w0_q         <= w0_d;
      w1_q         <= w1_d;
      w2_q         <= w2_d;
      w3_q         <= w3_d;
      fill_q       <= fill_d;
      s1_valid_q   <= s1_valid_d;
      s1_last_q    <= s1_last_d;
      p0_q         <= p0_d;
      p1_q         <= p1_d;
      p2_q         <= p2_d;
      p3_q         <= p3_d;
      s2_valid_q   <= s2_valid_d;
      s2_last_q    <= s2_last_d;
      sum_q        <= sum_d;
      s3_valid_q   <= s3_valid_d;
      s3_last_q    <= s3_last_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_sample_q <= out_sample_d;
    end
  end

endmodule

// File: tb/tb_intra_filter_accum.sv
module tb_intra_filter_accum;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_sample = 8'd0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_sample;
  logic       out_last;

  // Second instance with C1 overridden, used for the high-clip case.
  logic       in_valid2 = 1'b0;
  logic       in_ready2;
  logic       out_valid2;
  logic [7:0] out_sample2;
  logic       out_last2;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit rnd_mode = 1'b0;

  logic [8:0] exp_q[$];
  logic [8:0] exp2_q[$];
  int         out_cyc_q[$];
  int         acc_cyc;

  intra_filter_accum dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sample(out_sample), .out_last(out_last)
  );

  intra_filter_accum #(.C1(8'sd127)) dut_hi (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_sample(in_sample), .in_last(in_last),
    .out_valid(out_valid2), .out_ready(1'b1), .out_sample(out_sample2), .out_last(out_last2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always begin
    @(posedge clk);
    #1;
    out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Main monitor: pops the scoreboard on every output handshake and watches
  // backpressure behaviour while the output is stalled.
  logic [8:0] held;
  bit         held_v = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v && out_valid)
        check("stall_hold", int'({out_last, out_sample}), int'(held));
      if (out_valid && !out_ready) begin
        check("stall_in_ready", int'(in_ready), 0);
        held   = {out_last, out_sample};
        held_v = 1'b1;
      end else if (out_valid) begin
        held_v = 1'b0;
        out_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("out_sample", int'(out_sample), int'(e[7:0]));
          check("out_last", int'(out_last), int'(e[8]));
        end
      end else begin
        held_v = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid2) begin
      if (exp2_q.size() == 0) begin
        check("unexpected_output_hi", 1, 0);
      end else begin
        logic [8:0] e;
        e = exp2_q.pop_front();
        check("out_sample_hi", int'(out_sample2), int'(e[7:0]));
        check("out_last_hi", int'(out_last2), int'(e[8]));
      end
    end
  end

  task automatic send(input logic [7:0] s, input logic l, input bit to2 = 1'b0);
    int waited = 0;
    @(negedge clk);
    in_sample = s;
    in_last   = l;
    in_valid  = 1'b1;
    in_valid2 = to2;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 0, 1);
    end else begin
      @(posedge clk);
      #1;
      acc_cyc = cyc;
    end
    in_valid  = 1'b0;
    in_valid2 = 1'b0;
  endtask

  task automatic push(input logic [7:0] s, input logic l);
    exp_q.push_back({l, s});
  endtask

  task automatic drain();
    int waited = 0;
    while ((exp_q.size() != 0 || exp2_q.size() != 0) && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() != 0 || exp2_q.size() != 0)
      check("drain_timeout", exp_q.size() + exp2_q.size(), 0);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    logic [7:0] ramp_exp[7];
    ramp_exp = '{8'd25, 8'd35, 8'd44, 8'd54, 8'd63, 8'd73, 8'd83};

    repeat (3) @(negedge clk);
    check("reset_in_ready", int'(in_ready), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_sample", int'(out_sample), 0);
    check("reset_out_last", int'(out_last), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Four samples of 100: (6100+32)>>6 = 95, three clocks after the accept.
    push(8'd95, 1'b1);
    out_cyc_q.delete();
    for (int i = 0; i < 4; i++) send(8'd100, i == 3);
    drain();
    check("latency_count", out_cyc_q.size(), 1);
    if (out_cyc_q.size() == 1) check("latency", out_cyc_q[0] - acc_cyc, 3);

    // Fill restarts between lines.
    push(8'd28, 1'b1);
    send(8'd0, 1'b0); send(8'd0, 1'b0); send(8'd0, 1'b0); send(8'd255, 1'b1);
    push(8'd215, 1'b1);
    send(8'd255, 1'b0); send(8'd255, 1'b0); send(8'd255, 1'b0); send(8'd0, 1'b1);
    drain();

    // Low clip: (-765+32)>>>6 = -12 -> 0.
    push(8'd0, 1'b1);
    send(8'd255, 1'b0); send(8'd0, 1'b0); send(8'd0, 1'b0); send(8'd0, 1'b1);
    drain();

    // All 255: default set gives 243; C1=127 instance saturates at 255.
    push(8'd243, 1'b1);
    exp2_q.push_back({1'b1, 8'd255});
    for (int i = 0; i < 4; i++) send(8'd255, i == 3, 1'b1);
    drain();

    // Ramp line of 10, no backpressure: 7 outputs on consecutive clocks.
    out_cyc_q.delete();
    for (int i = 0; i < 7; i++) push(ramp_exp[i], i == 6);
    for (int i = 1; i <= 10; i++) send(8'(i * 10), i == 10);
    drain();
    check("ramp_count", out_cyc_q.size(), 7);
    if (out_cyc_q.size() == 7) check("ramp_consecutive", out_cyc_q[6] - out_cyc_q[0], 6);

    // Same ramp with random backpressure.
    rnd_mode = 1'b1;
    out_cyc_q.delete();
    for (int i = 0; i < 7; i++) push(ramp_exp[i], i == 6);
    for (int i = 1; i <= 10; i++) send(8'(i * 10), i == 10);
    drain();
    check("ramp_rnd_count", out_cyc_q.size(), 7);
    rnd_mode = 1'b0;
    repeat (2) @(negedge clk);

    // Short line is dropped; following line of 50s gives 48.
    send(8'd7, 1'b0); send(8'd8, 1'b0); send(8'd9, 1'b1);
    push(8'd48, 1'b1);
    for (int i = 0; i < 4; i++) send(8'd50, i == 3);
    drain();

    // Reset with two windows in flight: nothing may emerge afterwards.
    for (int i = 0; i < 5; i++) send(8'd100, i == 4);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_out_valid", int'(out_valid), 0);
    check("midreset_in_ready", int'(in_ready), 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    push(8'd95, 1'b1);
    for (int i = 0; i < 4; i++) send(8'd100, i == 3);
    drain();

    check("scoreboard_empty", exp_q.size(), 0);
    check("scoreboard_hi_empty", exp2_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/intra_filter_accum.md
Name: intra_filter_accum

Overview:
- Streaming 4-tap angular interpolation stage. It is the consumer end of the shift-add constant-multiplier blocks.
- Accepts one unsigned 8-bit reference sample per handshake and keeps a sliding 4-sample window.
- Multiplies the window by a fixed signed coefficient set, sums, rounds, shifts by 6 and clips to produce one 8-bit predicted sample per window position.
- Sits between the reference-sample buffer and the prediction output writer.

Parameters:
- C0, -3, signed coefficient applied to the oldest window sample
- C1, 34, coefficient for window sample 1
- C2, 23, coefficient for window sample 2
- C3, 7, coefficient for the newest window sample
- CW, 8, signed coefficient width (coefficients in -128..127)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block accepts input this cycle
- in_sample  in  8  unsigned reference sample
- in_last  in  1  marks final sample of a reference line
- out_valid  out  1  predicted sample valid
- out_ready  in  1  downstream accepts output
- out_sample  out  8  unsigned clipped predicted sample
- out_last  out  1  output produced by the window closed with in_last

Behaviour:
- Interface decision: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset: in_ready=0 while rst_n=0. out_valid=0, out_sample=0, out_last=0. Window registers=0, fill count=0, all pipeline valids=0.
- Global advance: adv = !out_valid || out_ready. in_ready = adv (one cycle after reset release). The whole pipeline stalls when adv=0; no register changes.
- Accept: in_valid && in_ready.
  - Window shifts: w0<=w1, w1<=w2, w2<=w3, w3<=in_sample.
  - fill <= min(fill+1, 4); it saturates at 4.
- Stage-1 launch: on accept with post-update fill==4, s1_valid<=1 and s1_last<=in_last. Otherwise, whenever adv=1, s1_valid<=0.
- Line end: after accepting in_last=1, fill<=0. The next accepted sample starts a fresh window.
  - A line of N samples (N>=4) yields exactly N-3 outputs; the last one carries out_last=1.
  - A line with N<4 yields no output, and its in_last is dropped.
- Stage 1 to stage 2: products p_i = w_i * C_i, with samples zero-extended. Each product is 17-bit signed. Product and s1_last registered into stage 2.
- Stage 2 to stage 3: sum = p0+p1+p2+p3+32, 19-bit signed, registered.
- Stage 3 to output: r = sum >>> 6 (arithmetic). out_sample = 0 if r<0, 255 if r>255, else r[7:0]. Registered into out_sample, with out_valid and out_last.
- Latency: output is presented 3 clocks after the accept that completes a window, absent stalls.
- Throughput: one output per clock in steady state.
- Backpressure: out_valid=1 && out_ready=0 holds out_sample and out_last stable, and in_ready=0. Nothing is lost or duplicated.
- Simultaneous events: an accept and an output handshake in the same cycle are both honoured.
  - An in_last accept and a new window launch in the same cycle: the window launches with last=1, then fill clears.
- Reset mid-operation: all in-flight outputs are discarded and fill=0. The next line starts from an empty window.
- Default coefficients sum to 61, not 64. The arithmetic is defined by the parameters and must not be normalised.

Test Plan:
- Reset, then line of 4 samples all 100, out_ready=1 -> one output after 3 clocks: (6100+32)>>6 = 95, out_last=1.
- Line 0,0,0,255 then 255,255,255,0 as second line -> first line outputs (1785+32)>>6 = 28. Second line outputs (-765+8670+5865+32)>>6 = 215. Confirms the fill reset between lines.
- Window 255,0,0,0 -> sum = -765+32 = -733, r = -12 -> out_sample = 0 (low clip). Override C1=127, all samples 255 -> 255 (high clip).
- Line of 10 samples 10,20,...,100 with out_ready=1 -> 7 outputs on consecutive clocks matching the golden model; out_last only on the 7th.
- Same 10-sample line with out_ready toggled randomly -> identical 7-value sequence; in_ready=0 whenever out_valid && !out_ready; out_sample stable during stalls.
- Line of 3 samples with in_last, then line of 4 samples of 50 -> first line produces nothing. Second line produces (3050+32)>>6 = 48, out_last=1.
- Assert rst_n low for 1 cycle while 2 outputs are in flight -> out_valid drops immediately; no stale outputs after release.
